parity_frame_davio: RTL and testbench

- Parametrised, sequential successor to the 7-bit combinational parity block.
- Accumulates XOR parity over a multi-word frame of WIDTH-bit words, using a valid/ready stream interface.
- Mode-selectable: generate or check, even or odd parity. Reports word count and a saturating error count.
- Sits between a word-stream source and a framing/CRC stage in the lab datapath.

---
 rtl/parity_frame_davio.sv | 133 +++++++++++++
 tb/tb_parity_frame_davio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_davio.sv
// Frame-level XOR parity over a valid/ready stream of WIDTH-bit words.
// Generates or checks even/odd parity and counts words and errored frames.
module parity_frame_davio #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             cfg_odd,
  input  logic             cfg_check,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] out_words,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic             odd_q, odd_d;
  logic             check_q, check_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic accept, first_word, word_par;
  logic odd_eff, check_eff, acc_next, par_next, err_next;

  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid && in_ready;
  assign first_word = (state_q == IDLE);
  assign word_par   = ^in_data;

  // The first word of a frame sees the live config and restarts the accumulator.
  assign odd_eff   = first_word ? cfg_odd   : odd_q;
  assign check_eff = first_word ? cfg_check : check_q;
  assign acc_next  = first_word ? word_par  : (acc_q ^ word_par);
  assign par_next  = acc_next ^ odd_eff;
  assign err_next  = check_eff && (par_next != in_par);

  // NOTE: every variable gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    odd_d     = odd_q;
    check_d   = check_q;
    par_d     = par_q;
    err_d     = err_q;
    words_d   = words_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_next;
          odd_d   = odd_eff;
          check_d = check_eff;
          if (first_word)
            words_d = CNT_W'(1);
          else if (words_q != CNT_MAX)
            words_d = words_q + CNT_W'(1);

          if (in_last) begin
            state_d = HOLD;
            par_d   = par_next;
            err_d   = err_next;
            if (err_next && (err_cnt_q != CNT_MAX))
              err_cnt_d = err_cnt_q + CNT_W'(1);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear has priority over a coincident increment.
    if (clr_err)
      err_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      odd_q     <= 1'b0;
      check_q   <= 1'b0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      odd_q     <= odd_d;
      check_q   <= check_d;
      par_q     <= par_d;
      err_q     <= err_d;
      words_q   <= words_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_parity = par_q;
  assign out_err    = err_q;
  assign out_words  = words_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_davio.sv
// Self-checking bench: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream; a frame-level model predicts parity, error and saturating counts.
module tb_parity_frame_davio;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_last, in_par, cfg_odd, cfg_check;
  logic         out_ready, clr_err;
  logic [W-1:0] in_data;

  logic         rdy8, vld8, par8, err8;
  logic [7:0]   words8, ecnt8;
  logic         rdy2, vld2, par2, err2;
  logic [1:0]   words2, ecnt2;

  int n_cmp = 0;
  int n_err = 0;
  int m_err8 = 0;
  int m_err2 = 0;
  logic [W-1:0] frame_q[$];

  always #5 clk = ~clk;

  parity_frame_davio #(.WIDTH(W), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_last(in_last), .in_par(in_par),
    .cfg_odd(cfg_odd), .cfg_check(cfg_check), .out_valid(vld8),
    .out_ready(out_ready), .out_parity(par8), .out_err(err8),
    .out_words(words8), .err_count(ecnt8), .clr_err(clr_err)
  );

  parity_frame_davio #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .in_last(in_last), .in_par(in_par),
    .cfg_odd(cfg_odd), .cfg_check(cfg_check), .out_valid(vld2),
    .out_ready(out_ready), .out_parity(par2), .out_err(err2),
    .out_words(words2), .err_count(ecnt2), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"},   32'(rdy8),   32'd1);
    check({tag, " out_valid"},  32'(vld8),   32'd0);
    check({tag, " out_parity"}, 32'(par8),   32'd0);
    check({tag, " out_err"},    32'(err8),   32'd0);
    check({tag, " out_words"},  32'(words8), 32'd0);
    check({tag, " err_count"},  32'(ecnt8),  32'd0);
    check({tag, " err_count2"}, 32'(ecnt2),  32'd0);
  endtask

  task automatic check_result(input string tag, input bit ep, input bit ee,
                              input int w8, input int w2);
    check({tag, " out_valid"},  32'(vld8),   32'd1);
    check({tag, " in_ready"},   32'(rdy8),   32'd0);
    check({tag, " out_parity"}, 32'(par8),   32'(ep));
    check({tag, " out_err"},    32'(err8),   32'(ee));
    check({tag, " out_words"},  32'(words8), 32'(w8));
    check({tag, " out_words2"}, 32'(words2), 32'(w2));
    check({tag, " err_count"},  32'(ecnt8),  32'(m_err8));
    check({tag, " err_count2"}, 32'(ecnt2),  32'(m_err2));
  endtask

  // Sends frame_q as one frame; config is presented with the first word and
  // scrambled afterwards so that only the latched values may matter.
  task automatic run_frame(input string tag, input bit odd, input bit chk, input bit par,
                           input bit clr_at_last, input int hold_cycles);
    int  n = frame_q.size();
    int  ones = 0;
    bit  exp_par, exp_err;
    int  w8, w2;
    foreach (frame_q[i]) ones += $countones(frame_q[i]);
    exp_par = ((ones % 2) == 1) ^ odd;
    exp_err = chk && (exp_par != par);
    w8 = (n > 255) ? 255 : n;
    w2 = (n > 3) ? 3 : n;

    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_data   = frame_q[i];
      in_last   = (i == n - 1);
      in_par    = (i == n - 1) ? par : 1'($urandom);
      clr_err   = clr_at_last && (i == n - 1);
      if (i == 0) begin
        cfg_odd   = odd;
        cfg_check = chk;
      end else begin
        cfg_odd   = 1'($urandom);
        cfg_check = 1'($urandom);
      end
      check({tag, " ready_for_word"}, 32'(rdy8), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr_err  = 1'b0;

    if (clr_at_last) begin
      m_err8 = 0;
      m_err2 = 0;
    end else if (exp_err) begin
      m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
      m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
    end
    check_result(tag, exp_par, exp_err, w8, w2);

    // Backpressure: a word offered during HOLD must be ignored.
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      in_last   = 1'($urandom);
      in_par    = 1'($urandom);
      cfg_odd   = 1'($urandom);
      cfg_check = 1'($urandom);
      @(negedge clk);
      check_result({tag, " hold"}, exp_par, exp_err, w8, w2);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " released out_valid"}, 32'(vld8), 32'd0);
    check({tag, " released in_ready"},  32'(rdy8), 32'd1);
    check({tag, " released in_ready2"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_par = 1'b0;
    cfg_odd = 1'b0; cfg_check = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, even, generate.
    frame_q = '{7'b1011001};
    run_frame("single", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Eight ones: odd then even generate.
    frame_q = '{7'h7F, 7'h01, 7'h00};
    run_frame("gen_odd", 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_frame("gen_even", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Check mode: mismatch then match.
    run_frame("chk_bad", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_frame("chk_good", 1'b0, 1'b1, 1'b0, 1'b0, 5);

    // Word-count saturation on the narrow instance.
    frame_q = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
    run_frame("five_words", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Error-count saturation, then clear coinciding with an errored frame.
    frame_q = '{7'h03};
    for (int k = 0; k < 4; k++) run_frame("err_sat", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_frame("err_clr", 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Reset two words into a frame.
    in_valid = 1'b1; in_data = 7'h15; in_last = 1'b0; cfg_odd = 1'b1; cfg_check = 1'b1;
    @(negedge clk);
    in_data = 7'h2A;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_err8 = 0;
    m_err2 = 0;
    check_reset_state("mid_reset");
    frame_q = '{7'h01};
    run_frame("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 6);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(W'($urandom));
      run_frame("random", 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
